sfq_toggle_decoder: RTL and testbench

- Receive-side converter for the toggle-encoded SFQ pulse nets used in the netlist-simulation models. On those nets every transition (rise or fall) is one pulse.
- Samples N data nets plus one SFQ clock net on the synchronous system clock and turns the pulses of each SFQ clock window into one binary word.
- Buffers the words in a small FIFO with a valid/ready output, so benches and wrappers can read cell outputs (for example s/cout of an adder) as ordinary logic.

---
 rtl/sfq_toggle_decoder.sv | 165 ++++++++++++++++
 tb/tb_sfq_toggle_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfq_toggle_decoder.sv
// sfq_toggle_decoder: turns toggle-encoded SFQ pulse nets into binary words.
// Each transition on a net is one pulse. The data pulses seen between two
// SFQ clock pulses form one word. Words are queued in a small FIFO that the
// consumer drains through a valid/ready handshake.
module sfq_toggle_decoder #(
    parameter int WIDTH       = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         tog_data,
    input  logic                     tog_clk,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_overflow,
    output logic                     err_multi
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int NN = WIDTH + 1;       // data nets plus the SFQ clock net

    // Synchronizer chains and edge detection; the clock net is the top bit.
    logic [NN-1:0]    raw_s;
    logic [NN-1:0]    sync_r [SYNC_STAGES];
    logic [NN-1:0]    prev_r;
    logic [NN-1:0]    pulse_r;
    logic [WIDTH-1:0] data_pulse_s;
    logic             clk_pulse_s;

    // Window accumulation
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next_s;
    logic             multi_hit_s;
    logic [WIDTH-1:0] cap_word_r;
    logic             cap_valid_r;
    logic             err_multi_r;

    // FIFO
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      rd_ptr_next_s;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_next_s;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] head_next_s;
    logic             out_valid_r;
    logic             err_overflow_r;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;

    assign raw_s        = {tog_clk, tog_data};
    assign data_pulse_s = pulse_r[WIDTH-1:0];
    assign clk_pulse_s  = pulse_r[WIDTH];

    // Synchronize every net and flag a pulse whenever the synchronized level changes.
    // Reset loads the live input everywhere so no phantom pulse follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= raw_s;
            end
            prev_r  <= raw_s;
            pulse_r <= {NN{1'b0}};
        end else begin
            sync_r[0] <= raw_s;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
            pulse_r <= sync_r[SYNC_STAGES-1] ^ prev_r;
            prev_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    // Merge this cycle's data pulses into the window and spot repeated pulses.
    always_comb begin
        acc_next_s  = acc_r | data_pulse_s;
        multi_hit_s = |(acc_r & data_pulse_s);
    end

    // Accumulate the window; a clock pulse captures it (same-cycle data included) and restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {WIDTH{1'b0}};
            cap_word_r  <= {WIDTH{1'b0}};
            cap_valid_r <= 1'b0;
            err_multi_r <= 1'b0;
        end else begin
            cap_valid_r <= clk_pulse_s;
            if (clk_pulse_s) begin
                cap_word_r <= acc_next_s;
                acc_r      <= {WIDTH{1'b0}};
            end else begin
                acc_r <= acc_next_s;
            end
            if (multi_hit_s) begin
                err_multi_r <= 1'b1;
            end
        end
    end

    // FIFO control: a pop in the same cycle makes room for a push even when full.
    always_comb begin
        full_s        = (level_r == LW'(DEPTH));
        pop_s         = out_valid_r & out_ready;
        push_s        = cap_valid_r & (~full_s | pop_s);
        drop_s        = cap_valid_r & full_s & ~pop_s;
        rd_ptr_next_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + {{AW{1'b0}}, 1'b1};
            2'b01:   level_next_s = level_r - {{AW{1'b0}}, 1'b1};
            default: level_next_s = level_r;
        endcase
        if (level_next_s == {LW{1'b0}}) begin
            head_next_s = out_data_r;
        end else if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_next_s[AW-1:0])) begin
            head_next_s = cap_word_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
        end
    end

    // FIFO storage; contents only matter where the pointers say so, hence no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= cap_word_r;
        end
    end

    // FIFO pointers, occupancy, registered head word and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r       <= {(AW+1){1'b0}};
            rd_ptr_r       <= {(AW+1){1'b0}};
            level_r        <= {LW{1'b0}};
            out_data_r     <= {WIDTH{1'b0}};
            out_valid_r    <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            out_valid_r <= (level_next_s != {LW{1'b0}});
            out_data_r  <= head_next_s;
            if (drop_s) begin
                err_overflow_r <= 1'b1;
            end
        end
    end

    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign level        = level_r;
    assign err_overflow = err_overflow_r;
    assign err_multi    = err_multi_r;

endmodule

// File: tb/tb_sfq_toggle_decoder.sv
// Self-checking bench for sfq_toggle_decoder. The reference model is a queue
// of expected words: each SFQ clock toggle enqueues the set of data nets
// toggled since the previous one; every handshake must pop the matching word.
module tb_sfq_toggle_decoder;

    localparam int W = 2;
    localparam int D = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] tog_data;
    logic         tog_clk;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   level;
    logic         err_overflow;
    logic         err_multi;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q [$];
    logic         exp_ovf;
    logic         exp_multi;

    sfq_toggle_decoder #(.WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .tog_data     (tog_data),
        .tog_clk      (tog_clk),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .err_overflow (err_overflow),
        .err_multi    (err_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: a handshake happening at this edge is scored against the model first.
    task automatic tick();
        logic [W-1:0] w;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 8'(exp_q.size()), 8'(1));
            end else begin
                w = exp_q.pop_front();
                check("word", 8'(out_data), 8'(w));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_multi = 1'b0;
    endtask

    // Model: a new word is lost only if nobody drains and D words are already held.
    task automatic model_push(input logic [W-1:0] w);
        if (out_ready == 1'b0 && exp_q.size() >= D) exp_ovf = 1'b1;
        else exp_q.push_back(w);
    endtask

    task automatic send_window(input logic [W-1:0] mask, input int gap);
        tog_data = tog_data ^ mask;
        ticks(gap);
        tog_clk = ~tog_clk;
        model_push(mask);
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_valid"}, 8'(out_valid), 8'(0));
        check({tag, "_level"}, 8'(level), 8'(0));
        check({tag, "_ovf"},   8'(err_overflow), 8'(0));
        check({tag, "_multi"}, 8'(err_multi), 8'(0));
    endtask

    initial begin
        logic [W-1:0] m;
        rst = 1'b0; tog_data = 2'b00; tog_clk = 1'b0; out_ready = 1'b0;
        exp_ovf = 1'b0; exp_multi = 1'b0;

        // 1. reset state, then idle with nets low and with nets high
        do_reset();
        check_idle_state("reset");
        check("reset_data", 8'(out_data), 8'(0));
        ticks(50);
        check_idle_state("idle0");
        tog_data = 2'b11; tog_clk = 1'b1;
        do_reset();
        ticks(50);
        check_idle_state("idle1");

        // 2. words 01 then 11, with exact latency to out_valid
        out_ready = 1'b1;
        tog_data = tog_data ^ 2'b01;
        ticks(3);
        tog_clk = ~tog_clk;
        model_push(2'b01);
        ticks(S + 2);
        check("lat_early", 8'(out_valid), 8'(0));
        tick();
        check("lat_exact", 8'(out_valid), 8'(1));
        check("lat_data", 8'(out_data), 8'(2'b01));
        ticks(6);
        send_window(2'b11, 2);
        ticks(10);

        // 3. data and clock on the same edge, then an empty window
        send_window(2'b10, 0);
        ticks(8);
        send_window(2'b00, 2);
        ticks(10);
        check("after3_left", 8'(exp_q.size()), 8'(0));

        // 4. double pulse on one net within a window
        tog_data = tog_data ^ 2'b01;
        ticks(4);
        tog_data = tog_data ^ 2'b01;
        ticks(3);
        tog_clk = ~tog_clk;
        model_push(2'b01);
        exp_multi = 1'b1;
        ticks(10);
        check("multi_set", 8'(err_multi), 8'(exp_multi));
        send_window(2'b10, 2);
        ticks(10);
        check("multi_sticky", 8'(err_multi), 8'(exp_multi));

        // 5. overflow with the consumer stalled, then drain
        do_reset();
        check("multi_cleared", 8'(err_multi), 8'(0));
        out_ready = 1'b0;
        send_window(2'b01, 2); ticks(8);
        send_window(2'b10, 2); ticks(8);
        send_window(2'b11, 2); ticks(8);
        send_window(2'b00, 2); ticks(8);
        send_window(2'b01, 2); ticks(8);
        check("full_level", 8'(level), 8'(exp_q.size()));
        check("full_ovf", 8'(err_overflow), 8'(exp_ovf));
        check("hold_data", 8'(out_data), 8'(exp_q[0]));
        ticks(3);
        check("hold_data2", 8'(out_data), 8'(exp_q[0]));
        out_ready = 1'b1;
        ticks(10);
        check("drained_valid", 8'(out_valid), 8'(0));
        check("drained_level", 8'(level), 8'(exp_q.size()));
        check("ovf_sticky", 8'(err_overflow), 8'(1));

        // 6a. push and pop on the same edge while full
        do_reset();
        send_window(2'b11, 2); ticks(8);
        send_window(2'b01, 2); ticks(8);
        send_window(2'b10, 2); ticks(8);
        send_window(2'b11, 2); ticks(8);
        check("prefill_level", 8'(level), 8'(D));
        tog_data = tog_data ^ 2'b10;
        ticks(2);
        tog_clk = ~tog_clk;
        ticks(S + 2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_q.push_back(2'b10);
        ticks(6);
        check("pushpop_level", 8'(level), 8'(D));
        check("pushpop_ovf", 8'(err_overflow), 8'(0));
        out_ready = 1'b1;
        ticks(12);
        check("pushpop_drained", 8'(exp_q.size()), 8'(0));

        // 6b. reset between a data pulse and the closing clock pulse
        do_reset();
        tog_data = tog_data ^ 2'b01;
        ticks(6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tog_clk = ~tog_clk;
        model_push(2'b00);
        ticks(10);
        check("stale_left", 8'(exp_q.size()), 8'(0));

        // 7. randomized windows with a randomly stalling consumer
        do_reset();
        for (int k = 0; k < 25; k++) begin
            m = W'($urandom_range(0, 3));
            tog_data = tog_data ^ m;
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                out_ready = (level >= 3'd2) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
            end
            tog_clk = ~tog_clk;
            exp_q.push_back(m);
            for (int g = $urandom_range(5, 8); g > 0; g--) begin
                out_ready = (level >= 3'd2) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
            end
        end
        out_ready = 1'b1;
        ticks(15);
        check("rand_left", 8'(exp_q.size()), 8'(0));
        check("rand_level", 8'(level), 8'(0));
        check("rand_ovf", 8'(err_overflow), 8'(0));
        check("rand_multi", 8'(err_multi), 8'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
